// File: rtl/uart_receiver.sv
// 8N1 UART receive path with mid-bit sampling, valid/ack handshake, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
module uart_receiver #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DIV_COUNTER = CLK_FREQ / BAUD_RATE,
    parameter int HALF_DIV    = DIV_COUNTER / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rx_ack,
    output logic [7:0] RxData,
    output logic       rx_valid,
    output logic       busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       framing_err,
    output logic       overrun_err
);

    localparam int CW = $clog2(DIV_COUNTER);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_COUNTER - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // Even parity over data plus received parity bit; 1 means the frame is bad.
    function automatic logic parity_bad(input logic [7:0] data, input logic par_bit);
        return ^{data, par_bit};
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          busy_q, busy_d;
    logic          framing_err_q, framing_err_d;
    logic          overrun_err_q, overrun_err_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic          rx_prev_q, rx_prev_d;
    logic          fall_s;
    logic          frame_ok_s;
    logic          par_fail_s;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_q, par_bit_d;
    logic          parity_err_q, parity_err_d;
`endif

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'd0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            framing_err_q <= framing_err_d;
            overrun_err_q <= overrun_err_d;
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            rx_prev_q     <= rx_prev_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= par_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // Next-state, sampling and handshake logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        framing_err_d = 1'b0;
        overrun_err_d = 1'b0;
        frame_ok_s    = 1'b0;
        par_fail_s    = 1'b0;
        rx_meta_d     = RxD;
        rx_sync_d     = rx_meta_q;
        rx_prev_d     = rx_sync_q;
        fall_s        = rx_prev_q & ~rx_sync_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d     = par_bit_q;
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (!rx_sync_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_sync_q;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    par_fail_s   = parity_bad(shift_q, par_bit_q);
                    parity_err_d = par_fail_s;
`endif
                    framing_err_d = ~rx_sync_q;
                    frame_ok_s    = rx_sync_q & ~par_fail_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A completing frame may be loaded in the same cycle the consumer acks the old one.
        if (frame_ok_s) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign RxData      = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign framing_err = framing_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scoreboard of expected bytes plus error-pulse monitors.
module tb_uart_receiver;

    localparam int DIV  = 434;
    localparam int HALF = 217;
`ifdef UART_RX_PARITY_EN
    localparam int FBITS = 10;
`else
    localparam int FBITS = 9;
`endif
    localparam int EXP_LAT = 2 + HALF + FBITS * DIV + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RxD = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] RxData;
    logic       rx_valid;
    logic       busy;
    logic       framing_err;
    logic       overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int pulse_long = 0;
    logic fe_p = 1'b0;
    logic ov_p = 1'b0;
    logic pe_p = 1'b0;
    logic done = 1'b0;

    uart_receiver #(
        .CLK_FREQ (50_000_000),
        .BAUD_RATE(115200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RxD        (RxD),
        .rx_ack     (rx_ack),
        .RxData     (RxData),
        .rx_valid   (rx_valid),
        .busy       (busy),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .framing_err(framing_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // Count error pulses and flag any pulse lasting more than one cycle.
    always @(negedge clk) begin
        logic pe_now;
`ifdef UART_RX_PARITY_EN
        pe_now = parity_err;
`else
        pe_now = 1'b0;
`endif
        if (framing_err) fe_cnt <= fe_cnt + 1;
        if (overrun_err) ov_cnt <= ov_cnt + 1;
        if (pe_now) pe_cnt <= pe_cnt + 1;
        if ((framing_err && fe_p) || (overrun_err && ov_p) || (pe_now && pe_p))
            pulse_long <= pulse_long + 1;
        fe_p <= framing_err;
        ov_p <= overrun_err;
        pe_p <= pe_now;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        tick(DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input logic expect_load);
        if (expect_load) exp_q.push_back(d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_bit);
        RxD = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_vec++;
        if ({RxData, rx_valid, busy, framing_err, overrun_err} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 000",
                     {RxData, rx_valid, busy, framing_err, overrun_err});
        end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_single();
        int lat;
        int fe0;
        int ov0;
        logic [7:0] exp_b;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
            begin
                while (!rx_valid && lat < 6000) begin
                    tick(1);
                    lat++;
                end
            end
        join
        n_vec++;
        if (lat < EXP_LAT - 2 || lat > EXP_LAT) begin
            n_err++;
            $display("FAIL single_latency: got %0d expected %0d..%0d", lat, EXP_LAT - 2, EXP_LAT);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL single_data: got scoreboard empty expected one byte");
        end else begin
            exp_b = exp_q.pop_front();
            if (!rx_valid || RxData !== exp_b) begin
                n_err++;
                $display("FAIL single_data: got valid=%b data=%h expected valid=1 data=%h",
                         rx_valid, RxData, exp_b);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
            n_err++;
            $display("FAIL single_status: got busy=%b fe=%0d ov=%0d expected busy=0 fe=%0d ov=%0d",
                     busy, fe_cnt, ov_cnt, fe0, ov0);
        end
        ack_pulse();
        n_vec++;
        if (rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack: got rx_valid=%b expected 0", rx_valid);
        end
        tick(DIV);
    endtask

    task automatic test_glitch();
        int fe0;
        int ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        RxD = 1'b0;
        tick(50);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_high: got %b expected 1", busy);
        end
        tick(50);
        RxD = 1'b1;
        tick(130);
        n_vec++;
        if (busy !== 1'b0 || rx_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
            n_err++;
            $display("FAIL glitch_reject: got busy=%b valid=%b fe=%0d ov=%0d expected 0 0 %0d %0d",
                     busy, rx_valid, fe_cnt, ov_cnt, fe0, ov0);
        end
        tick(DIV);
    endtask

    task automatic test_framing();
        int fe0;
        logic [7:0] exp_b;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(2 * DIV);
        n_vec++;
        if (fe_cnt != fe0 + 1 || pulse_long != 0 || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL framing_flag: got fe=%0d long=%0d valid=%b expected fe=%0d long=0 valid=0",
                     fe_cnt, pulse_long, rx_valid, fe0 + 1);
        end
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        tick(DIV);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL framing_recover: got scoreboard empty expected one byte");
        end else begin
            exp_b = exp_q.pop_front();
            if (!rx_valid || RxData !== exp_b) begin
                n_err++;
                $display("FAIL framing_recover: got valid=%b data=%h expected valid=1 data=%h",
                         rx_valid, RxData, exp_b);
            end
        end
        ack_pulse();
        tick(DIV);
    endtask

    task automatic test_back_to_back();
        int ov0;
        logic [7:0] exp_b;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        tick(DIV);
        n_vec++;
        if (ov_cnt != ov0 + 1 || pulse_long != 0) begin
            n_err++;
            $display("FAIL overrun_flag: got ov=%0d long=%0d expected ov=%0d long=0",
                     ov_cnt, pulse_long, ov0 + 1);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL overrun_keep: got scoreboard empty expected one byte");
        end else begin
            exp_b = exp_q.pop_front();
            if (!rx_valid || RxData !== exp_b) begin
                n_err++;
                $display("FAIL overrun_keep: got valid=%b data=%h expected valid=1 data=%h",
                         rx_valid, RxData, exp_b);
            end
        end
        ack_pulse();
        n_vec++;
        if (rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_ack: got rx_valid=%b expected 0", rx_valid);
        end
        tick(DIV);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [7:0] exp_b;
        int fe0;
        int ov0;
        d = 8'hF0;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        tick(2);
        n_vec++;
        if ({RxData, rx_valid, busy, framing_err, overrun_err} !== 12'h000) begin
            n_err++;
            $display("FAIL midframe_reset: got %h expected 000",
                     {RxData, rx_valid, busy, framing_err, overrun_err});
        end
        reset = 1'b0;
        RxD = 1'b1;
        tick(2 * DIV);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
        tick(DIV);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL after_reset_data: got scoreboard empty expected one byte");
        end else begin
            exp_b = exp_q.pop_front();
            if (!rx_valid || RxData !== exp_b || fe_cnt != fe0 || ov_cnt != ov0) begin
                n_err++;
                $display("FAIL after_reset_data: got valid=%b data=%h fe=%0d ov=%0d expected 1 %h %0d %0d",
                         rx_valid, RxData, fe_cnt, ov_cnt, exp_b, fe0, ov0);
            end
        end
        ack_pulse();
        tick(DIV);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0;
        logic [7:0] exp_b;
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        tick(DIV);
        n_vec++;
        if (pe_cnt != pe0 + 1 || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL parity_flag: got pe=%0d valid=%b expected pe=%0d valid=0",
                     pe_cnt, rx_valid, pe0 + 1);
        end
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        tick(DIV);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL parity_good: got scoreboard empty expected one byte");
        end else begin
            exp_b = exp_q.pop_front();
            if (!rx_valid || RxData !== exp_b || pe_cnt != pe0 + 1) begin
                n_err++;
                $display("FAIL parity_good: got valid=%b data=%h pe=%0d expected 1 %h %0d",
                         rx_valid, RxData, pe_cnt, exp_b, pe0 + 1);
            end
        end
        ack_pulse();
        tick(DIV);
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_vec++;
        if (exp_q.size() != 0 || pulse_long != 0) begin
            n_err++;
            $display("FAIL final_state: got pending=%0d long=%0d expected 0 0", exp_q.size(), pulse_long);
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
        end
    end

endmodule
